song_reader: RTL and testbench

- Sequencer that walks one 32-entry song in the song ROM and issues its notes to the note-player/voice-allocator stage over a valid/ready handshake.
- Paces the song with "wait" entries counted in beat ticks.
- Sits between the song ROM (7-bit address, 16-bit data, registered read) and the note players.
- Controlled by the top-level play/song-select logic.

---
 rtl/song_reader_pkg.sv | 32 +++
 rtl/song_reader_if.sv | 16 +
 rtl/song_reader_beat_countdown.sv | 27 ++
 rtl/song_reader.sv | 174 +++++++++++++++++
 tb/tb_song_reader.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/song_reader_pkg.sv
// Shared definitions for the song reader: ROM entry field layout, song
// length, the sequencer state encoding and entry classification helpers.
package song_pkg;

  localparam int ENTRY_W  = 16;
  localparam int W_BIT    = 15;
  localparam int NOTE_MSB = 14;
  localparam int NOTE_LSB = 9;
  localparam int DUR_MSB  = 8;
  localparam int DUR_LSB  = 3;
  localparam int SONG_LEN = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_READ,
    S_DISPATCH,
    S_WAIT,
    S_DONE
  } state_t;

  // End marker: wait flag set with a zero duration.
  function automatic logic is_end_marker(input logic [ENTRY_W-1:0] entry);
    return entry[W_BIT] && (entry[DUR_MSB:DUR_LSB] == '0);
  endfunction

  // Any entry carrying a non-zero note is offered to the players.
  function automatic logic is_dispatch(input logic [ENTRY_W-1:0] entry);
    return entry[NOTE_MSB:NOTE_LSB] != '0;
  endfunction

endpackage

// File: rtl/song_reader_if.sv
// Note handshake between the song reader (master) and the note players.
// valid/ready: the master raises note_valid with note/duration and holds
// all three unchanged until a cycle where note_valid and note_ready are both
// high; that cycle is the transfer. The master never withdraws a note.
interface song_reader_if #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6
);
  logic              note_valid;
  logic              note_ready;
  logic [NOTE_W-1:0] note;
  logic [DUR_W-1:0]  duration;

  modport master (output note_valid, output note, output duration, input note_ready);
  modport slave  (input note_valid, input note, input duration, output note_ready);
endinterface

// File: rtl/song_reader_beat_countdown.sv
// Beat countdown: loadable down-counter that steps once per enabled beat
// and saturates at zero. Shared with the note players for note lengths.
module beat_countdown #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero
);
  logic [W-1:0] count;

  // Load has priority so a beat coinciding with a load is not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/song_reader.sv
// Song reader: walks one 32-entry song in the song ROM, issues notes over
// the note handshake and paces the song with beat-counted wait entries.
// Optional build macro SONG_READER_LOOP_EN: when defined, the end of a song
// restarts the same song from entry 0 while play is high.
module song_reader
  import song_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int SONG_SEL_W = 2,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic [SONG_SEL_W-1:0] song,
  input  logic                  beat,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [ENTRY_W-1:0]    rom_dout,
  song_reader_if.master         notes,
  output logic                  busy,
  output logic                  song_done,
  output state_t                fsm_state
);
  localparam int IDX_W = ADDR_W - SONG_SEL_W;

  state_t                state;
  logic [SONG_SEL_W-1:0] song_r;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_next;
  logic                  idx_last;
  logic                  entry_w;     // wait flag of the entry being dispatched

  logic                  rd_w;
  logic [NOTE_W-1:0]     rd_note;
  logic [DUR_W-1:0]      rd_dur;
  logic                  rd_end;
  logic                  rd_disp;

  logic                  adv;
  logic                  cnt_load;
  logic [DUR_W-1:0]      cnt_val;
  logic                  cnt_tick;
  logic                  cnt_zero;
  logic                  accept;
  logic                  unused_reserved;

  assign rd_w            = rom_dout[W_BIT];
  assign rd_note         = rom_dout[NOTE_MSB:NOTE_LSB];
  assign rd_dur          = rom_dout[DUR_MSB:DUR_LSB];
  assign rd_end          = is_end_marker(rom_dout);
  assign rd_disp         = is_dispatch(rom_dout);
  assign unused_reserved = ^rom_dout[DUR_LSB-1:0];

  assign idx_next  = idx + 1'b1;
  assign idx_last  = (idx == IDX_W'(SONG_LEN - 1));
  assign accept    = notes.note_valid && notes.note_ready;
  assign fsm_state = state;

  // Countdown control: load from a wait entry in READ or from an accepted
  // dispatch with the wait flag; only beats seen in WAIT while playing count.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (state == S_READ && !rd_end && !rd_disp && rd_w) begin
      cnt_load = 1'b1;
      cnt_val  = rd_dur;
    end else if (state == S_DISPATCH && accept && entry_w) begin
      cnt_load = 1'b1;
      cnt_val  = notes.duration;
    end
  end

  assign cnt_tick = (state == S_WAIT) && beat && play;

  // Advance request: the current entry is finished and the walk moves on.
  always_comb begin
    adv = 1'b0;
    case (state)
      S_READ:     adv = !rd_end && !rd_disp && !rd_w;
      S_DISPATCH: adv = !entry_w && (!notes.note_valid || notes.note_ready);
      S_WAIT:     adv = cnt_zero;
      default:    adv = 1'b0;
    endcase
  end

  beat_countdown #(.W(DUR_W)) u_countdown (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tick     (cnt_tick),
    .zero     (cnt_zero)
  );

  // Sequencer FSM; the shared advance step at the end overrides the
  // per-state transition when the current entry is finished.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      song_r           <= '0;
      idx              <= '0;
      rom_addr         <= '0;
      entry_w          <= 1'b0;
      notes.note_valid <= 1'b0;
      notes.note       <= '0;
      notes.duration   <= '0;
      busy             <= 1'b0;
      song_done        <= 1'b0;
    end else begin
      song_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (play) begin
            song_r   <= song;
            idx      <= '0;
            rom_addr <= {song, {IDX_W{1'b0}}};
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: state <= S_READ;
        S_READ: begin
          if (rd_end) begin
            song_done <= 1'b1;
            state     <= S_DONE;
          end else if (rd_disp) begin
            notes.note       <= rd_note;
            notes.duration   <= rd_dur;
            notes.note_valid <= 1'b1;
            entry_w          <= rd_w;
            state            <= S_DISPATCH;
          end else if (rd_w) begin
            state <= S_WAIT;
          end
        end
        S_DISPATCH: begin
          if (accept) begin
            notes.note_valid <= 1'b0;
            if (entry_w) state <= S_WAIT;
          end
        end
        S_WAIT: ;
        S_DONE: begin
`ifdef SONG_READER_LOOP_EN
          if (play) begin
            idx      <= '0;
            rom_addr <= {song_r, {IDX_W{1'b0}}};
            state    <= S_FETCH;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
`else
          busy  <= 1'b0;
          state <= S_IDLE;
`endif
        end
        default: state <= S_IDLE;
      endcase

      if (adv) begin
        if (idx_last) begin
          song_done <= 1'b1;
          state     <= S_DONE;
        end else if (play) begin
          idx      <= idx_next;
          rom_addr <= {song_r, idx_next};
          state    <= S_FETCH;
        end
      end
    end
  end
endmodule

// File: tb/tb_song_reader.sv
// Testbench for song_reader: directed scenarios on a hand-built song plus
// randomized songs checked against a reference walk of the ROM image.
module tb_song_reader;
  import song_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        play = 1'b0;
  logic        beat = 1'b0;
  logic [1:0]  song = 2'd0;
  logic [6:0]  rom_addr;
  logic [15:0] rom_dout;
  logic        busy;
  logic        song_done;
  state_t      fsm_state;
  logic [15:0] rom [128];

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  song_reader_if nif ();

  song_reader dut (
    .clk       (clk),
    .reset     (reset),
    .play      (play),
    .song      (song),
    .beat      (beat),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .notes     (nif),
    .busy      (busy),
    .song_done (song_done),
    .fsm_state (fsm_state)
  );

  // clock and registered ROM model
  always #5 clk = ~clk;
  always @(posedge clk) rom_dout <= rom[rom_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; play = 1'b0; beat = 1'b0; nif.note_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic pulse_beats(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      beat = 1'b1; step(); beat = 1'b0;
      repeat (gap) step();
    end
  endtask

  function automatic logic [15:0] ent(input logic w, input logic [5:0] n, input logic [5:0] d);
    logic [2:0] rsv;
    rsv = 3'($urandom_range(0, 7));
    return {w, n, d, rsv};
  endfunction

  // reference: notes a song issues, in order, from the ROM image alone
  function automatic void build_expected(input int base);
    exp_q.delete();
    for (int i = 0; i < SONG_LEN; i++) begin
      logic [15:0] e;
      e = rom[base + i];
      if (e[15] && e[8:3] == 6'd0) break;
      if (e[14:9] != 6'd0) exp_q.push_back(e[14:3]);
    end
  endfunction

  task automatic test_reset();
    step();
    checks++; if (rom_addr !== 7'd0) begin errors++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
    checks++; if (nif.note_valid !== 1'b0) begin errors++; $display("FAIL reset_note_valid got %b want 0", nif.note_valid); end
    checks++; if (nif.note !== 6'd0 || nif.duration !== 6'd0) begin errors++; $display("FAIL reset_note got %0d/%0d want 0/0", nif.note, nif.duration); end
    checks++; if (busy !== 1'b0 || song_done !== 1'b0) begin errors++; $display("FAIL reset_flags busy %b done %b want 0 0", busy, song_done); end
    checks++; if (fsm_state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", fsm_state); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_chord();
    int hs[$];
    int cyc;
    build_expected(0);
    song = 2'd0; nif.note_ready = 1'b1; play = 1'b1;
    cyc = 0;
    while (hs.size() < 3 && cyc < 40) begin
      if (nif.note_valid && nif.note_ready) begin
        checks++;
        if ({nif.note, nif.duration} !== exp_q[0]) begin
          errors++; $display("FAIL chord_note%0d got %0d/%0d want %0d/%0d", hs.size(), nif.note, nif.duration, exp_q[0][11:6], exp_q[0][5:0]);
        end
        void'(exp_q.pop_front());
        hs.push_back(cyc);
      end
      step(); cyc++;
    end
    checks++; if (hs.size() != 3) begin errors++; $display("FAIL chord_timeout got %0d notes want 3", hs.size()); end
    if (hs.size() == 3) begin
      for (int k = 1; k < 3; k++) begin
        checks++; if (hs[k] - hs[k-1] != 3) begin errors++; $display("FAIL chord_interval got %0d want 3", hs[k] - hs[k-1]); end
      end
    end
    repeat (2) step();
    checks++; if (rom_addr !== 7'd3 || fsm_state !== S_WAIT) begin errors++; $display("FAIL chord_wait_addr got %0d state %0d want 3 WAIT", rom_addr, fsm_state); end
  endtask

  task automatic test_pause_wait();
    nif.note_ready = 1'b0;
    pulse_beats(20, 3);
    play = 1'b0;
    pulse_beats(5, 3);
    checks++; if (rom_addr !== 7'd3 || nif.note_valid !== 1'b0) begin errors++; $display("FAIL pause_frozen addr %0d valid %b want 3 0", rom_addr, nif.note_valid); end
    play = 1'b1;
    pulse_beats(27, 3);
    checks++; if (rom_addr !== 7'd3) begin errors++; $display("FAIL wait_47_beats addr %0d want 3", rom_addr); end
    pulse_beats(1, 3);
    checks++; if (rom_addr !== 7'd4 || nif.note_valid !== 1'b1) begin errors++; $display("FAIL wait_48_beats addr %0d valid %b want 4 1", rom_addr, nif.note_valid); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (nif.note_valid !== 1'b1 || {nif.note, nif.duration} !== exp_q[0] || rom_addr !== 7'd4) begin
        errors++; $display("FAIL hold_cycle%0d valid %b note %0d/%0d addr %0d want 1 %0d/%0d 4", i, nif.note_valid, nif.note, nif.duration, rom_addr, exp_q[0][11:6], exp_q[0][5:0]);
      end
      if (i == 3) play = 1'b0;
      if (i == 7) play = 1'b1;
      step();
    end
    nif.note_ready = 1'b1;
    checks++; if (nif.note_valid !== 1'b1 || {nif.note, nif.duration} !== exp_q[0]) begin errors++; $display("FAIL accept_note got %0d/%0d want %0d/%0d", nif.note, nif.duration, exp_q[0][11:6], exp_q[0][5:0]); end
    void'(exp_q.pop_front());
    step();
    nif.note_ready = 1'b0;
    checks++; if (nif.note_valid !== 1'b0 || fsm_state !== S_WAIT) begin errors++; $display("FAIL accept_drop valid %b state %0d want 0 WAIT", nif.note_valid, fsm_state); end
  endtask

  task automatic test_end_marker();
    logic found;
    pulse_beats(8, 2);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (song_done) found = 1'b1; else step();
    end
    checks++; if (!found) begin errors++; $display("FAIL end_timeout song_done got 0 want 1"); end
    checks++; if (rom_addr !== 7'd31 || busy !== 1'b1) begin errors++; $display("FAIL end_addr addr %0d busy %b want 31 1", rom_addr, busy); end
    step();
    checks++; if (song_done !== 1'b0) begin errors++; $display("FAIL end_pulse_width got %b want 0", song_done); end
`ifdef SONG_READER_LOOP_EN
    checks++; if (rom_addr !== 7'd0 || busy !== 1'b1) begin errors++; $display("FAIL loop_restart addr %0d busy %b want 0 1", rom_addr, busy); end
`else
    checks++; if (busy !== 1'b0 || fsm_state !== S_IDLE) begin errors++; $display("FAIL end_idle busy %b state %0d want 0 IDLE", busy, fsm_state); end
`endif
    play = 1'b0;
    do_reset();
  endtask

  task automatic test_song1_wrap();
    int amin, amax, cyc;
    logic found;
    build_expected(32);
    amin = 127; amax = 0; found = 1'b0;
    song = 2'd1; play = 1'b1; nif.note_ready = 1'b1;
    for (cyc = 0; cyc < 600 && !found; cyc++) begin
      if (cyc == 10) song = 2'd2;
      beat = (cyc % 4 == 0);
      if (busy) begin
        if (int'(rom_addr) < amin) amin = int'(rom_addr);
        if (int'(rom_addr) > amax) amax = int'(rom_addr);
      end
      if (nif.note_valid && nif.note_ready) begin
        checks++;
        if (exp_q.size() == 0 || {nif.note, nif.duration} !== exp_q[0]) begin
          errors++; $display("FAIL song1_note got %0d/%0d expected left %0d", nif.note, nif.duration, exp_q.size());
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (song_done) begin
        found = 1'b1;
        play = 1'b0;
        checks++; if (rom_addr !== 7'd63) begin errors++; $display("FAIL song1_last_addr got %0d want 63", rom_addr); end
      end else begin
        step();
      end
    end
    beat = 1'b0;
    checks++; if (!found) begin errors++; $display("FAIL song1_timeout song_done got 0 want 1"); end
    checks++; if (amin < 32 || amax > 63) begin errors++; $display("FAIL song1_range got %0d..%0d want 32..63", amin, amax); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL song1_missing got %0d left want 0", exp_q.size()); end
    do_reset();
  endtask

  task automatic test_async_reset();
    song = 2'd0; play = 1'b1; nif.note_ready = 1'b1;
    for (int i = 0; i < 40 && fsm_state != S_WAIT; i++) step();
    checks++; if (fsm_state !== S_WAIT) begin errors++; $display("FAIL areset_reach_wait state %0d want WAIT", fsm_state); end
    pulse_beats(5, 1);
    #3 reset = 1'b1;
    #1;
    checks++; if (rom_addr !== 7'd0 || busy !== 1'b0 || song_done !== 1'b0) begin errors++; $display("FAIL areset_ctrl addr %0d busy %b done %b want 0 0 0", rom_addr, busy, song_done); end
    checks++; if (nif.note_valid !== 1'b0 || nif.note !== 6'd0 || nif.duration !== 6'd0) begin errors++; $display("FAIL areset_note valid %b note %0d/%0d want 0 0/0", nif.note_valid, nif.note, nif.duration); end
    step(); step();
    reset = 1'b0;
    step();
    build_expected(0);
    begin
      logic found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        if (nif.note_valid) found = 1'b1; else step();
      end
      checks++;
      if (!found || rom_addr !== 7'd0 || {nif.note, nif.duration} !== exp_q[0]) begin
        errors++; $display("FAIL areset_restart addr %0d note %0d/%0d want 0 %0d/%0d", rom_addr, nif.note, nif.duration, exp_q[0][11:6], exp_q[0][5:0]);
      end
    end
    do_reset();
  endtask

  task automatic test_random();
    for (int run = 0; run < 4; run++) begin
      int s, base, cyc;
      logic found, bad_addr, prev_nv, prev_rdy;
      logic [11:0] prev_nd;
      s = $urandom_range(2, 3);
      base = s * 32;
      for (int i = 0; i < SONG_LEN; i++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r <= 3)      rom[base+i] = ent(1'b0, 6'($urandom_range(1, 63)), 6'($urandom_range(0, 63)));
        else if (r == 4) rom[base+i] = ent(1'b1, 6'($urandom_range(1, 63)), 6'($urandom_range(0, 5)));
        else if (r <= 6) rom[base+i] = ent(1'b1, 6'd0, 6'($urandom_range(1, 5)));
        else if (r == 9 && $urandom_range(0, 3) == 0) rom[base+i] = ent(1'b1, 6'($urandom_range(0, 63)), 6'd0);
        else             rom[base+i] = ent(1'b0, 6'd0, 6'($urandom_range(0, 63)));
      end
      build_expected(base);
      song = 2'(s); play = 1'b1;
      found = 1'b0; bad_addr = 1'b0; prev_nv = 1'b0; prev_rdy = 1'b0; prev_nd = '0;
      for (cyc = 0; cyc < 4000 && !found; cyc++) begin
        if (prev_nv && !prev_rdy) begin
          checks++;
          if (nif.note_valid !== 1'b1 || {nif.note, nif.duration} !== prev_nd) begin
            errors++; $display("FAIL rand_stable valid %b note %0d/%0d want 1 %0d/%0d", nif.note_valid, nif.note, nif.duration, prev_nd[11:6], prev_nd[5:0]);
          end
        end
        if (busy && rom_addr[6:5] !== 2'(s)) bad_addr = 1'b1;
        nif.note_ready = ($urandom_range(0, 9) < 6);
        beat = ($urandom_range(0, 2) == 0);
        if (cyc > 0) play = ($urandom_range(0, 19) < 17);
        if (nif.note_valid && nif.note_ready) begin
          checks++;
          if (exp_q.size() == 0 || {nif.note, nif.duration} !== exp_q[0]) begin
            errors++; $display("FAIL rand_note run %0d got %0d/%0d expected left %0d", run, nif.note, nif.duration, exp_q.size());
          end
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        prev_nv = nif.note_valid; prev_rdy = nif.note_ready; prev_nd = {nif.note, nif.duration};
        if (song_done) begin
          found = 1'b1;
          play = 1'b0;
        end
        step();
      end
      beat = 1'b0; nif.note_ready = 1'b0;
      checks++; if (!found) begin errors++; $display("FAIL rand_timeout run %0d song_done got 0 want 1", run); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_missing run %0d got %0d left want 0", run, exp_q.size()); end
      checks++; if (bad_addr) begin errors++; $display("FAIL rand_addr_range run %0d left song %0d", run, s); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_idle run %0d busy %b want 0", run, busy); end
      do_reset();
    end
  endtask

  initial begin
    nif.note_ready = 1'b0;
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[0]  = ent(1'b0, 6'd52, 6'd48);
    rom[1]  = ent(1'b0, 6'd56, 6'd32);
    rom[2]  = ent(1'b0, 6'd59, 6'd16);
    rom[3]  = ent(1'b1, 6'd0, 6'd48);
    rom[4]  = ent(1'b1, 6'd60, 6'd8);
    rom[7]  = ent(1'b0, 6'd0, 6'd5);
    rom[31] = ent(1'b1, 6'd0, 6'd0);
    rom[37] = ent(1'b0, 6'd33, 6'd7);
    rom[52] = ent(1'b1, 6'd0, 6'd2);
    rom[63] = ent(1'b0, 6'd44, 6'd1);

    test_reset();
    test_chord();
    test_pause_wait();
    test_backpressure();
    test_end_marker();
    test_song1_wrap();
    test_async_reset();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
